// File: rtl/ex_wb_stage_if.sv
// Signal bundle for the EX->WB stage: execute inputs, data-memory port and write-back port.
// The stage itself takes the slave view; the surrounding pipeline/memory takes the master view.
interface ex_wb_stage_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_regwr;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_alu_res;
    logic [XLEN-1:0] ex_pc4;
    logic [1:0]      ex_wbsel;
    logic            ex_memrd;
    logic            ex_memwr;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_store_data;
    logic            flush;
    logic            stall;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;
    logic            wb_regwr;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            mem_err;

    modport slave (
        input  ex_valid, ex_regwr, ex_rd, ex_alu_res, ex_pc4, ex_wbsel,
               ex_memrd, ex_memwr, ex_funct3, ex_store_data, flush,
               dmem_ack, dmem_rdata,
        output stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               wb_regwr, wb_rd, wb_data, mem_err
    );

    modport master (
        output ex_valid, ex_regwr, ex_rd, ex_alu_res, ex_pc4, ex_wbsel,
               ex_memrd, ex_memwr, ex_funct3, ex_store_data, flush,
               dmem_ack, dmem_rdata,
        input  stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               wb_regwr, wb_rd, wb_data, mem_err
    );
endinterface

// File: rtl/ex_wb_stage.sv
// Execute->writeback pipeline register with a req/ack data-memory access controller.
//   state  | meaning
//   S_IDLE | no access outstanding; ex_* captured when valid and not flushed
//   S_WAIT | access outstanding; dmem_req high, upstream stalled, timeout counting
module ex_wb_stage #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_wb_stage_if.slave  stg
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rd_q, rd_d;
    logic            wb_regwr_q, wb_regwr_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            mem_err_q, mem_err_d;

    logic [1:0]      ex_ofs;
    logic            ex_mem;
    logic            ex_misal;
    logic [3:0]      ex_be;
    logic [XLEN-1:0] ex_wdata;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [XLEN-1:0] ld_data;

    assign ex_ofs   = stg.ex_alu_res[1:0];
    assign ex_mem   = stg.ex_memrd | stg.ex_memwr;
    assign ex_wdata = stg.ex_store_data << {ex_ofs, 3'b000};

    always_comb begin
        ex_misal = 1'b0;
        ex_be    = 4'b1111;
        case (stg.ex_funct3[1:0])
            2'b00: ex_be = 4'b0001 << ex_ofs;
            2'b01: begin
                ex_be    = 4'b0011 << ex_ofs;
                ex_misal = ex_ofs[0];
            end
            default: ex_misal = |ex_ofs;
        endcase
    end

    // Memory returns the aligned word; pick the lane addressed by the request.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_b = stg.dmem_rdata[7:0];
            2'b01:   ld_b = stg.dmem_rdata[15:8];
            2'b10:   ld_b = stg.dmem_rdata[23:16];
            default: ld_b = stg.dmem_rdata[31:24];
        endcase
        ld_h = addr_q[1] ? stg.dmem_rdata[31:16] : stg.dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_b[7]}}, ld_b};
            3'b001:  ld_data = {{(XLEN-16){ld_h[15]}}, ld_h};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_b};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_h};
            default: ld_data = stg.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        wb_regwr_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        mem_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (stg.ex_valid && !stg.flush) begin
                    if (ex_mem) begin
                        if (ex_misal) begin
                            mem_err_d = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = '0;
                            addr_d  = stg.ex_alu_res;
                            wdata_d = ex_wdata;
                            be_d    = ex_be;
                            we_d    = stg.ex_memwr;
                            f3_d    = stg.ex_funct3;
                            rd_d    = stg.ex_rd;
                        end
                    end else if (stg.ex_regwr && stg.ex_rd != 5'd0) begin
                        wb_regwr_d = 1'b1;
                        wb_rd_d    = stg.ex_rd;
                        wb_data_d  = (stg.ex_wbsel == 2'b10) ? stg.ex_pc4 : stg.ex_alu_res;
                    end
                end
            end
            S_WAIT: begin
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (stg.dmem_ack) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (!we_q && rd_q != 5'd0) begin
                        wb_regwr_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = ld_data;
                    end
                end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            rd_q       <= '0;
            wb_regwr_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            wb_regwr_q <= wb_regwr_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign stg.stall      = (state_q == S_WAIT);
    assign stg.dmem_req   = (state_q == S_WAIT);
    assign stg.dmem_we    = we_q;
    assign stg.dmem_addr  = addr_q;
    assign stg.dmem_be    = be_q;
    assign stg.dmem_wdata = wdata_q;
    assign stg.wb_regwr   = wb_regwr_q;
    assign stg.wb_rd      = wb_rd_q;
    assign stg.wb_data    = wb_data_q;
    assign stg.mem_err    = mem_err_q;
endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: directed cases then random instruction streams against a
// transaction-level model of the stage (expected write-back, memory request and error per instruction).
module tb_ex_wb_stage;
    localparam int XLEN        = 32;
    localparam int MEM_TIMEOUT = 16;
    localparam int N_RAND      = 250;

    typedef struct packed {
        logic        valid;
        logic        flush;
        logic        regwr;
        logic        memrd;
        logic        memwr;
        logic [4:0]  rd;
        logic [1:0]  wbsel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] sd;
    } instr_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    logic [4:0]  last_rd;
    logic [31:0] last_data;
    instr_t seq [0:N_RAND];

    ex_wb_stage_if #(.XLEN(XLEN)) bus ();

    ex_wb_stage #(.XLEN(XLEN), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stg   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write-back port: strobe as expected; rd/data follow the last real write otherwise hold.
    task automatic check_wb(input string tag, input bit exp_wr, input logic [4:0] rd, input logic [31:0] data);
        if (exp_wr) begin
            last_rd   = rd;
            last_data = data;
        end
        check_val({tag, "_regwr"}, 32'(bus.wb_regwr), 32'(exp_wr));
        check_val({tag, "_rd"},    32'(bus.wb_rd),    32'(last_rd));
        check_val({tag, "_data"},  bus.wb_data,       last_data);
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit misal(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr % 4) % acc_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
        int m;
        m = (1 << acc_size(f3)) - 1;
        return 4'(m << int'(addr % 4));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] sd, input logic [31:0] addr);
        return sd << (8 * int'(addr % 4));
    endfunction

    function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * int'(addr % 4));
        case (f3)
            3'b000:  return v[7]  ? ((v & 32'hFF)   | 32'hFFFF_FF00) : (v & 32'hFF);
            3'b001:  return v[15] ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
            3'b100:  return v & 32'hFF;
            3'b101:  return v & 32'hFFFF;
            default: return word;
        endcase
    endfunction

    function automatic instr_t mk_alu(input logic [4:0] rd, input logic [31:0] v, input bit fl);
        instr_t t;
        t       = '0;
        t.valid = 1'b1;
        t.flush = fl;
        t.regwr = 1'b1;
        t.rd    = rd;
        t.alu   = v;
        t.pc4   = 32'h0000_4444;
        return t;
    endfunction

    function automatic instr_t mk_mem(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] sd, input logic [4:0] rd);
        instr_t t;
        t       = '0;
        t.valid = 1'b1;
        t.regwr = !st;
        t.memrd = !st;
        t.memwr = st;
        t.wbsel = st ? 2'b00 : 2'b01;
        t.f3    = f3;
        t.alu   = addr;
        t.sd    = sd;
        t.rd    = rd;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int kind;
        logic [2:0] f3s [0:4];
        f3s  = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        kind = $urandom_range(0, 9);
        t       = '0;
        t.valid = ($urandom_range(0, 9) != 0);
        t.flush = ($urandom_range(0, 9) == 0);
        t.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        t.alu   = $urandom;
        t.pc4   = $urandom;
        t.sd    = $urandom;
        t.f3    = f3s[$urandom_range(0, 4)];
        if (kind < 4) begin
            t.regwr = 1'($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       t.wbsel = 2'b00;
                1:       t.wbsel = 2'b10;
                default: t.wbsel = 2'b11;
            endcase
        end else begin
            if ($urandom_range(0, 9) < 6) t.alu = t.alu & 32'hFFFF_FFFC;
            t.memrd = (kind < 7) || (kind == 9);
            t.memwr = (kind >= 7);
            t.regwr = t.memrd && !t.memwr;
            t.wbsel = t.memwr ? 2'b00 : 2'b01;
        end
        return t;
    endfunction

    task automatic drive(input instr_t t);
        bus.ex_valid      = t.valid;
        bus.flush         = t.flush;
        bus.ex_regwr      = t.regwr;
        bus.ex_memrd      = t.memrd;
        bus.ex_memwr      = t.memwr;
        bus.ex_rd         = t.rd;
        bus.ex_wbsel      = t.wbsel;
        bus.ex_funct3     = t.f3;
        bus.ex_alu_res    = t.alu;
        bus.ex_pc4        = t.pc4;
        bus.ex_store_data = t.sd;
    endtask

    // Present one instruction; if it starts an access, hold `held` upstream while the
    // memory acks after `lat` idle WAIT cycles (lat >= MEM_TIMEOUT means never).
    task automatic issue(input instr_t in, input instr_t held, input int lat,
                         input logic [31:0] rdata, input bit wflush);
        bit acc;
        bit ismem;
        bit ld;
        int nwait;
        @(negedge clk);
        drive(in);
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = $urandom;
        @(posedge clk);
        #1;
        acc   = in.valid && !in.flush;
        ismem = in.memrd || in.memwr;
        ld    = in.memrd && !in.memwr;
        if (!acc || !ismem) begin
            check_wb("alu", acc && !ismem && in.regwr && in.rd != 5'd0, in.rd,
                     (in.wbsel == 2'b10) ? in.pc4 : in.alu);
            check_val("alu_stall", 32'(bus.stall),    0);
            check_val("alu_req",   32'(bus.dmem_req), 0);
            check_val("alu_err",   32'(bus.mem_err),  0);
        end else if (misal(in.f3, in.alu)) begin
            check_val("mis_err",   32'(bus.mem_err),  1);
            check_val("mis_req",   32'(bus.dmem_req), 0);
            check_val("mis_stall", 32'(bus.stall),    0);
            check_wb("mis", 1'b0, 5'd0, 32'd0);
        end else begin
            check_val("req",       32'(bus.dmem_req), 1);
            check_val("req_stall", 32'(bus.stall),    1);
            check_val("req_we",    32'(bus.dmem_we),  32'(in.memwr));
            check_val("req_addr",  bus.dmem_addr,     in.alu);
            check_val("req_be",    32'(bus.dmem_be),  32'(exp_be(in.f3, in.alu)));
            check_val("req_wdata", bus.dmem_wdata,    exp_wdata(in.sd, in.alu));
            check_val("req_err",   32'(bus.mem_err),  0);
            check_wb("req", 1'b0, 5'd0, 32'd0);
            @(negedge clk);
            drive(held);
            bus.flush = wflush;
            nwait = (lat >= MEM_TIMEOUT) ? MEM_TIMEOUT : lat;
            for (int k = 0; k < nwait; k++) begin
                @(posedge clk);
                #1;
                if (k == MEM_TIMEOUT - 1) begin
                    check_val("to_err",   32'(bus.mem_err),  1);
                    check_val("to_req",   32'(bus.dmem_req), 0);
                    check_val("to_stall", 32'(bus.stall),    0);
                    check_wb("to", 1'b0, 5'd0, 32'd0);
                end else begin
                    check_val("wait_stall", 32'(bus.stall),    1);
                    check_val("wait_req",   32'(bus.dmem_req), 1);
                    check_val("wait_addr",  bus.dmem_addr,     in.alu);
                    check_val("wait_err",   32'(bus.mem_err),  0);
                    check_val("wait_wbwr",  32'(bus.wb_regwr), 0);
                    @(negedge clk);
                end
            end
            if (lat < MEM_TIMEOUT) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = rdata;
                @(posedge clk);
                #1;
                check_wb("ack", ld && in.rd != 5'd0, in.rd, ld_val(in.f3, in.alu, rdata));
                check_val("ack_stall", 32'(bus.stall),    0);
                check_val("ack_req",   32'(bus.dmem_req), 0);
                check_val("ack_err",   32'(bus.mem_err),  0);
            end
        end
    endtask

    initial begin
        instr_t i_alu5, i_alu0, i_lb, i_lbu, i_sh, i_sw, i_lw, i_next, i_fl, i_lh, i_rst;
        int r;
        int lat;
        n_cmp     = 0;
        n_bad     = 0;
        last_rd   = '0;
        last_data = '0;
        rst_n     = 1'b0;
        drive('0);
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;

        #12;
        check_val("rst_stall",  32'(bus.stall),    0);
        check_val("rst_req",    32'(bus.dmem_req), 0);
        check_val("rst_err",    32'(bus.mem_err),  0);
        check_val("rst_be",     32'(bus.dmem_be),  0);
        check_val("rst_addr",   bus.dmem_addr,     0);
        check_wb("rst", 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        i_alu5 = mk_alu(5'd5, 32'h0000_1234, 1'b0);
        i_alu0 = mk_alu(5'd0, 32'h0000_5555, 1'b0);
        i_lb   = mk_mem(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7);
        i_lbu  = mk_mem(1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd8);
        i_sh   = mk_mem(1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 5'd0);
        i_sw   = mk_mem(1'b1, 3'b010, 32'h0000_0101, 32'h1111_2222, 5'd0);
        i_lw   = mk_mem(1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd9);
        i_next = mk_alu(5'd10, 32'h0000_CAFE, 1'b0);
        i_fl   = mk_alu(5'd11, 32'h0BAD_0BAD, 1'b1);
        i_lh   = mk_mem(1'b0, 3'b001, 32'h0000_0106, 32'h0, 5'd12);
        i_rst  = mk_alu(5'd13, 32'h0000_0D0D, 1'b0);

        issue(i_alu5, i_alu0, 0, 32'h0, 1'b0);
        issue(i_alu0, i_lb,   0, 32'h0, 1'b0);
        issue(i_lb,   i_lbu,  2, 32'h80FF_FFFF, 1'b1);
        issue(i_lbu,  i_sh,   2, 32'h80FF_FFFF, 1'b0);
        issue(i_sh,   i_sw,   1, 32'h0, 1'b0);
        issue(i_sw,   i_lw,   0, 32'h0, 1'b0);
        issue(i_lw,   i_next, MEM_TIMEOUT, 32'h0, 1'b0);
        issue(i_next, i_fl,   0, 32'h0, 1'b0);
        issue(i_fl,   i_lh,   0, 32'h0, 1'b0);
        issue(i_lh,   i_rst,  MEM_TIMEOUT - 1, 32'h8001_7FFF, 1'b0);

        // Asynchronous reset in the middle of an outstanding access.
        @(negedge clk);
        drive(i_lw);
        @(posedge clk);
        #1;
        check_val("pre_rst_req", 32'(bus.dmem_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_req",   32'(bus.dmem_req), 0);
        check_val("arst_stall", 32'(bus.stall),    0);
        last_rd   = '0;
        last_data = '0;
        check_wb("arst", 1'b0, 5'd0, 32'd0);
        drive('0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(i_rst, i_alu5, 0, 32'h0, 1'b0);

        for (int i = 0; i <= N_RAND; i++) seq[i] = rand_instr();
        for (int i = 0; i < N_RAND; i++) begin
            r = $urandom_range(0, 19);
            if (r < 14)      lat = r % 5;
            else if (r < 17) lat = MEM_TIMEOUT - 1;
            else             lat = MEM_TIMEOUT;
            issue(seq[i], seq[i+1], lat, $urandom, 1'($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
